// File: rtl/memwriter_pkg.sv
// memwriter_pkg: state encoding shared by the memwriter FSM.
package memwriter_pkg;

    // Loader states: waiting for start, accepting words, table complete
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

endpackage

// File: rtl/memwriter_genram.sv
// genram: simple dual-port RAM, one write port and one registered read port.
// The read is read-before-write: a same-address write in the same cycle
// is not visible until the following read.
module genram #(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Registered read port, cleared by reset so the output is defined
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_rdata <= '0;
        else       r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/memwriter.sv
// memwriter: loads a stream of words into consecutive RAM locations from 0
// and exposes a ROM-style synchronous read port.
// Optional: define MEMWRITER_WRAP_EN to keep loading circularly instead of
// stopping in FULL after the last location.
module memwriter
    import memwriter_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count
);

    localparam int            NPOS   = 2**AW;
    localparam logic [AW:0]   C_NPOS = (AW+1)'(NPOS);

    state_t        r_state;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_count;
    logic          r_din_ready;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_last;

    // start wins over a same-cycle handshake, so that word is dropped
    assign w_accept = din_valid && r_din_ready && !start;
    assign w_last   = (r_wptr == {AW{1'b1}});

    // Loader FSM with registered handshake/status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_wptr      <= '0;
            r_count     <= '0;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state     <= ST_LOAD;
                r_wptr      <= '0;
                r_count     <= '0;
                r_din_ready <= 1'b1;
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            r_wptr <= r_wptr + 1'b1;
`ifdef MEMWRITER_WRAP_EN
                            if (r_count != C_NPOS) r_count <= r_count + 1'b1;
                            if (w_last) r_done <= 1'b1;
`else
                            r_count <= r_count + 1'b1;
                            if (w_last) begin
                                r_done      <= 1'b1;
                                r_state     <= ST_FULL;
                                r_din_ready <= 1'b0;
                                r_busy      <= 1'b0;
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    genram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (w_accept),
        .waddr (r_wptr),
        .wdata (din),
        .raddr (addr),
        .rdata (data)
    );

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;

endmodule

// File: tb/tb_memwriter.sv
module tb_memwriter;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    memwriter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .addr      (addr),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_DATA = 0, S_RDY = 1, S_BUSY = 2, S_DONE = 3, S_CNT = 4;

    typedef struct {
        string name;
        int    sel;
        int    due;
        int    exp;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input string name, input int sel, input int lat, input int exp);
        exp_t e;
        e.name = name; e.sel = sel; e.due = cyc + lat; e.exp = exp;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            S_DATA:  return 32'(data);
            S_RDY:   return 32'(din_ready);
            S_BUSY:  return 32'(busy);
            S_DONE:  return 32'(done);
            default: return 32'(count);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                logic [31:0] act;
                act = get_sig(sbq[i].sel);
                n_cmp++;
                if (act !== 32'(sbq[i].exp)) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             sbq[i].name, act, sbq[i].exp, cyc);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input int exp, input string name);
        addr = AW'(a);
        expect_at(name, S_DATA, 1, exp);
        tick();
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0; addr = '0;
        tick(); tick();
        n_cmp++;
        if (data !== '0) begin
            n_bad++; $display("FAIL rst_now_data: got 0x%0h", data);
        end
        n_cmp++;
        if (din_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_now_ready: got %b", din_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_now_busy: got %b", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL rst_now_done: got %b", done);
        end
        n_cmp++;
        if (count !== '0) begin
            n_bad++; $display("FAIL rst_now_count: got 0x%0h", count);
        end
        expect_at("rst_data", S_DATA, 0, 0);
        expect_at("rst_ready", S_RDY, 0, 0);
        expect_at("rst_busy", S_BUSY, 0, 0);
        expect_at("rst_done", S_DONE, 0, 0);
        expect_at("rst_count", S_CNT, 0, 0);
        tick();
        rstn = 1'b1;
        tick();

`ifdef MEMWRITER_WRAP_EN
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din_valid = 1'b1;
            din = (i < 32) ? DW'(i) : DW'(14);
            expect_at("wrap_done", S_DONE, 0, (i == 32) ? 1 : 0);
            expect_at("wrap_count", S_CNT, 0, (i < 32) ? i : 32);
            expect_at("wrap_busy", S_BUSY, 0, 1);
            tick();
        end
        din_valid = 1'b0;
        expect_at("wrap_end_count", S_CNT, 0, 32);
        expect_at("wrap_end_busy", S_BUSY, 0, 1);
        expect_at("wrap_end_done", S_DONE, 0, 0);
        for (int a = 0; a < 8; a++) rd(a, 14, "wrap_overwrite");
        rd(8, 8, "wrap_keep8");
`else
        start = 1'b1; tick(); start = 1'b0;
        expect_at("load_busy", S_BUSY, 0, 1);
        for (int i = 0; i < 32; i++) begin
            din_valid = 1'b1;
            din = DW'(i);
            expect_at("load_ready", S_RDY, 0, 1);
            expect_at("load_count", S_CNT, 0, i);
            expect_at("load_done_low", S_DONE, 0, 0);
            tick();
        end
        expect_at("full_done", S_DONE, 0, 1);
        expect_at("full_count", S_CNT, 0, 32);
        expect_at("full_busy", S_BUSY, 0, 0);
        expect_at("full_ready", S_RDY, 0, 0);
        din = 4'hA;
        addr = 5'h05;
        expect_at("rd_05", S_DATA, 1, 5);
        tick();
        expect_at("done_pulse_end", S_DONE, 0, 0);
        expect_at("full_ready2", S_RDY, 0, 0);
        expect_at("full_count_hold", S_CNT, 0, 32);
        rd(0, 0, "full_nowrite_00");
        rd(0, 0, "full_nowrite_00b");
        rd(5'h15, 5, "rd_15");
        din_valid = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        din_valid = 1'b1; din = 4'h1; tick();
        din_valid = 1'b0; din = 4'h9; tick();
        din_valid = 1'b1; din = 4'h2; tick();
        din_valid = 1'b0; din = 4'h9; tick();
        din_valid = 1'b1; din = 4'h3; tick();
        din_valid = 1'b0;
        expect_at("gap_count", S_CNT, 0, 3);
        expect_at("gap_busy", S_BUSY, 0, 1);
        rd(0, 1, "gap_m0");
        rd(1, 2, "gap_m1");
        rd(2, 3, "gap_m2");
        rd(3, 3, "gap_m3_unchanged");

        for (int k = 0; k < 7; k++) begin
            din_valid = 1'b1;
            din = DW'(4 + k);
            addr = AW'(3 + k);
            expect_at("rbw_old", S_DATA, 1, 3 + k);
            tick();
        end
        din_valid = 1'b0;
        expect_at("mid_count10", S_CNT, 0, 10);
        start = 1'b1; din_valid = 1'b1; din = 4'hF; tick();
        start = 1'b0; din_valid = 1'b0;
        expect_at("restart_count", S_CNT, 0, 0);
        expect_at("restart_busy", S_BUSY, 0, 1);
        expect_at("restart_ready", S_RDY, 0, 1);
        din_valid = 1'b1; din = 4'hC; tick();
        din_valid = 1'b0;
        expect_at("restart_count1", S_CNT, 0, 1);
        rd(0, 12, "restart_m0");
        rd(9, 10, "restart_m9");
        rd(10, 10, "dropped_m10");
        rd(3, 4, "restart_m3");

        din_valid = 1'b1; din = 4'h7; tick();
        din = 4'h8; tick();
        din_valid = 1'b0;
        expect_at("pre_rst_count", S_CNT, 0, 3);
        addr = 5'h01;
        expect_at("pre_rst_data", S_DATA, 1, 7);
        tick();
        tick();
        rstn = 1'b0;
        expect_at("async_data", S_DATA, 0, 0);
        expect_at("async_ready", S_RDY, 0, 0);
        expect_at("async_busy", S_BUSY, 0, 0);
        expect_at("async_count", S_CNT, 0, 0);
        expect_at("async_done", S_DONE, 0, 0);
        tick();
        rstn = 1'b1;
        tick();
        expect_at("post_rst_ready", S_RDY, 0, 0);
        expect_at("post_rst_busy", S_BUSY, 0, 0);
        rd(1, 7, "post_rst_m1");
        rd(0, 12, "post_rst_m0");
        rd(2, 8, "post_rst_m2");
`endif

        tick(); tick(); tick();
        while (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked (due cycle %0d, now %0d)",
                     sbq[0].name, sbq[0].due, cyc);
            void'(sbq.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
